pcs_40g_am_sched: RTL and testbench



---
 rtl/pcs_40g_am_sched_if.sv | 24 ++
 rtl/pcs_40g_am_sched.sv | 87 ++++++++
 tb/tb_pcs_40g_am_sched.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcs_40g_am_sched_if.sv
// MAC/gearbox-facing signal bundle of the 40GBASE-R TX alignment-marker scheduler.
// The slave modport is the scheduler side; the master modport is the environment side.
interface pcs_40g_am_sched_if #(
  parameter int LANE_N = 4,
  parameter int CNT_W  = 14
);
  logic              gb_ready_i;
  logic              am_en_i;
  logic              ready_o;
  logic              am_v_o;
  logic              scr_en_o;
  logic [LANE_N-1:0] bip_clr_o;
  logic [CNT_W-1:0]  am_cnt_o;

  modport slave (
    input  gb_ready_i, am_en_i,
    output ready_o, am_v_o, scr_en_o, bip_clr_o, am_cnt_o
  );

  modport master (
    output gb_ready_i, am_en_i,
    input  ready_o, am_v_o, scr_en_o, bip_clr_o, am_cnt_o
  );
endinterface

// File: rtl/pcs_40g_am_sched.sv
// 40GBASE-R TX scheduler: interleaves one AM slot every AM_GAP data cycles,
// backpressures the MAC, gates the scrambler and clears the per-lane BIP accumulators.
module pcs_40g_am_sched #(
  parameter int LANE_N = 4,
  parameter int AM_GAP = 16383,
  parameter int CNT_W  = 14
) (
  input  logic               clk,
  input  logic               nreset,
  pcs_40g_am_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AM   = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_GAP - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ready;
  logic             w_am_slot;
  logic             w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Outputs depend on gb_ready_i combinationally so a gearbox skip stalls the MAC in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ready      = 1'b0;
    w_am_slot    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next = bus.am_en_i ? S_AM : S_DATA;
      end
      S_AM: begin
        w_am_slot = bus.gb_ready_i;
        if (bus.gb_ready_i) begin
          w_cnt_next   = '0;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_ready = bus.gb_ready_i;
        if (bus.gb_ready_i) begin
          if (w_cnt_last) begin
            w_cnt_next = '0;
            if (bus.am_en_i) begin
              w_state_next = S_AM;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign bus.ready_o  = w_ready;
  assign bus.scr_en_o = w_ready;
  assign bus.am_v_o   = w_am_slot;
  assign bus.am_cnt_o = r_cnt;

  for (genvar gi = 0; gi < LANE_N; gi++) begin : g_bip_clr
    assign bus.bip_clr_o[gi] = w_am_slot;
  end

endmodule

// File: tb/tb_pcs_40g_am_sched.sv
// Directed bench for pcs_40g_am_sched: short-gap instance for cycle-exact checks,
// full-gap instance for the 16383-cycle marker period under periodic gearbox skips.
module tb_pcs_40g_am_sched;

  localparam int LANE_N = 4;
  localparam int CNT_W  = 14;

  logic clk = 1'b0;
  logic nreset_a = 1'b0;
  logic nreset_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pcs_40g_am_sched_if #(.LANE_N(LANE_N), .CNT_W(CNT_W)) if_a ();
  pcs_40g_am_sched_if #(.LANE_N(LANE_N), .CNT_W(CNT_W)) if_b ();

  pcs_40g_am_sched #(.LANE_N(LANE_N), .AM_GAP(4), .CNT_W(CNT_W)) u_dut_a (
    .clk    (clk),
    .nreset (nreset_a),
    .bus    (if_a.slave)
  );

  pcs_40g_am_sched #(.LANE_N(LANE_N), .AM_GAP(16383), .CNT_W(CNT_W)) u_dut_b (
    .clk    (clk),
    .nreset (nreset_b),
    .bus    (if_b.slave)
  );

  // Observed tuple {ready, am_v, scr_en, bip_clr, cnt} of the short-gap instance.
  function automatic logic [CNT_W+6:0] obs_a();
    return {if_a.ready_o, if_a.am_v_o, if_a.scr_en_o, if_a.bip_clr_o, if_a.am_cnt_o};
  endfunction

  function automatic logic [CNT_W+6:0] exp_data(input logic gb, input int cnt);
    return {gb, 1'b0, gb, 4'h0, CNT_W'(cnt)};
  endfunction

  function automatic logic [CNT_W+6:0] exp_am(input logic gb, input int cnt);
    return {1'b0, gb, 1'b0, {4{gb}}, CNT_W'(cnt)};
  endfunction

  task automatic tick(input logic gb, input logic en);
    @(posedge clk);
    #1;
    if_a.gb_ready_i = gb;
    if_a.am_en_i    = en;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [CNT_W+6:0] e;
    if_a.gb_ready_i = 1'b1;
    if_a.am_en_i    = 1'b1;
    if_b.gb_ready_i = 1'b1;
    if_b.am_en_i    = 1'b1;
    nreset_a = 1'b0;
    repeat (3) @(negedge clk);
    e = '0;
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", obs_a(), e);
    end
    nreset_a = 1'b1;
    #1;
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL idle_cycle0: got %h expected %h", obs_a(), e);
    end
    $display("test_reset: outputs %h", obs_a());
  endtask

  // Cycle 1 is the AM slot, cycles 2..5 carry data with cnt 0..3, repeat every 5.
  task automatic test_am_period();
    logic [CNT_W+6:0] e;
    int k;
    for (int c = 1; c <= 11; c++) begin
      tick(1'b1, 1'b1);
      k = (c - 1) % 5;
      e = (k == 0) ? exp_am(1'b1, 0) : exp_data(1'b1, k - 1);
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL am_period c%0d: got %h expected %h", c, obs_a(), e);
      end
      $display("test_am_period: cycle %0d outputs %h", c, obs_a());
    end
  endtask

  task automatic test_skip_on_am();
    logic [CNT_W+6:0] e;
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 1'b1);
      e = exp_data(1'b1, c);
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL skip_pre c%0d: got %h expected %h", c, obs_a(), e);
      end
    end
    tick(1'b0, 1'b1);
    e = exp_am(1'b0, 0);
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL skip_am_due: got %h expected %h", obs_a(), e);
    end
    $display("test_skip_on_am: skipped AM cycle outputs %h", obs_a());
    tick(1'b1, 1'b1);
    e = exp_am(1'b1, 0);
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL skip_am_late: got %h expected %h", obs_a(), e);
    end
    tick(1'b1, 1'b1);
    e = exp_data(1'b1, 0);
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL skip_post_am: got %h expected %h", obs_a(), e);
    end
    tick(1'b0, 1'b1);
    e = exp_data(1'b0, 1);
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL skip_data_hold: got %h expected %h", obs_a(), e);
    end
    tick(1'b1, 1'b1);
    e = exp_data(1'b1, 1);
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL skip_data_resume: got %h expected %h", obs_a(), e);
    end
    $display("test_skip_on_am: resumed data outputs %h", obs_a());
  endtask

  task automatic test_async_reset();
    logic [CNT_W+6:0] e;
    tick(1'b1, 1'b1);
    e = exp_data(1'b1, 2);
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL arst_pre: got %h expected %h", obs_a(), e);
    end
    #2;
    nreset_a = 1'b0;
    #1;
    e = '0;
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL arst_immediate: got %h expected %h", obs_a(), e);
    end
    repeat (2) @(negedge clk);
    nreset_a = 1'b1;
    #1;
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL arst_idle: got %h expected %h", obs_a(), e);
    end
    tick(1'b1, 1'b1);
    e = exp_am(1'b1, 0);
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL arst_first_am: got %h expected %h", obs_a(), e);
    end
    tick(1'b1, 1'b1);
    e = exp_data(1'b1, 0);
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL arst_restart: got %h expected %h", obs_a(), e);
    end
    $display("test_async_reset: restart outputs %h", obs_a());
  endtask

  task automatic test_am_disabled();
    logic [CNT_W+6:0] e;
    #1;
    nreset_a = 1'b0;
    if_a.gb_ready_i = 1'b1;
    if_a.am_en_i    = 1'b0;
    repeat (2) @(negedge clk);
    nreset_a = 1'b1;
    #1;
    e = '0;
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL dis_idle: got %h expected %h", obs_a(), e);
    end
    for (int c = 1; c <= 9; c++) begin
      tick(1'b1, 1'b0);
      e = exp_data(1'b1, (c - 1) % 4);
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL dis_data c%0d: got %h expected %h", c, obs_a(), e);
      end
      $display("test_am_disabled: cycle %0d outputs %h", c, obs_a());
    end
  endtask

  // Invariants under random skips/enables; gaps between markers must be a nonzero multiple of 4.
  task automatic test_random();
    int viol = 0;
    int pulses = 0;
    int rcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      tick(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 7) != 0));
      if (if_a.ready_o && if_a.am_v_o) viol++;
      if (if_a.scr_en_o !== if_a.ready_o) viol++;
      if (if_a.am_cnt_o >= CNT_W'(4)) viol++;
      if (if_a.am_v_o) begin
        if (pulses > 0 && (rcnt == 0 || (rcnt % 4) != 0)) viol++;
        pulses++;
        rcnt = 0;
      end else if (if_a.ready_o) begin
        rcnt++;
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL rand_invariants: got %0d violations expected 0", viol);
    end
    checks++;
    if (pulses < 2) begin
      errors++;
      $display("FAIL rand_am_seen: got %0d markers expected at least 2", pulses);
    end
    $display("test_random: %0d markers, %0d violations", pulses, viol);
  endtask

  task automatic test_long_gap();
    int viol = 0;
    int pulses = 0;
    int rcnt = 0;
    int gaps[2] = '{0, 0};
    int cyc = 0;
    nreset_b = 1'b1;
    while (pulses < 3 && cyc < 40000) begin
      @(posedge clk);
      #1;
      if_b.gb_ready_i = ((cyc % 33) != 32);
      if_b.am_en_i    = 1'b1;
      @(negedge clk);
      if (if_b.ready_o && if_b.am_v_o) viol++;
      if (if_b.scr_en_o !== if_b.ready_o) viol++;
      if (if_b.am_v_o) begin
        if (pulses >= 1) gaps[pulses-1] = rcnt;
        pulses++;
        rcnt = 0;
      end else if (if_b.ready_o) begin
        rcnt++;
      end
      cyc++;
    end
    checks++;
    if (pulses < 3) begin
      errors++;
      $display("FAIL long_timeout: got %0d markers expected 3", pulses);
    end
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (gaps[g] != 16383) begin
        errors++;
        $display("FAIL long_gap%0d: got %0d ready cycles expected 16383", g, gaps[g]);
      end
      $display("test_long_gap: gap %0d = %0d ready cycles", g, gaps[g]);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL long_invariants: got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_am_period();
    test_skip_on_am();
    test_async_reset();
    test_am_disabled();
    test_random();
    test_long_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
